proc_param: RTL and testbench

Parametrised multi-cycle processor. It is the successor to the fixed 16-bit, four-instruction lab processor. Instructions and immediates arrive on DIN and are stepped by Run. Internal activity is exposed on a shared Bus, and Done is raised in the final cycle of each instruction. Top-level board wrappers map switches to DIN, keys to Resetn/Clock/Run, and LEDs to Bus/Done.

---
 rtl/proc_pkg.sv | 26 ++
 rtl/regn_param.sv | 31 +++
 rtl/proc_param.sv | 177 +++++++++++++++++
 tb/tb_proc_param.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// proc_pkg
// Shared definitions for the parametrised multi-cycle processor.
//   - opcode encodings carried in the top three bits of IR
//   - the T0..T3 control-step encoding
//   - regFieldWidth(): bits needed to name one of NREGS registers
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVNZ = 3'b101;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  function automatic int regFieldWidth(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regn_param.sv
// regn_param
// WIDTH-bit storage register used for R0..Rn, A, G and IR.
// Ports:
//   i_clk    - rising-edge clock
//   i_rst_n  - asynchronous active-low clear
//   i_en     - load enable
//   i_d      - data to load
//   o_q      - stored value
module regn_param #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/proc_param.sv
// proc_param
// Parametrised multi-cycle processor. An instruction is fetched from DIN in
// T0 when Run is high and executes over T1 (moves) or T1..T3 (ALU ops).
// Every register is loaded from the shared Bus, which is also exported.
// WIDTH must be at least 3 + 2*log2(NREGS); NREGS a power of two, 2..16.
// Ports:
//   Clock  - rising-edge clock
//   Resetn - asynchronous active-low reset (state, IR, A, G, Rn cleared)
//   DIN    - instruction word in T0, immediate during the mvi T1 cycle
//   Run    - starts an instruction when sampled high in T0
//   Done   - high during the final cycle of each instruction
//   Bus    - value on the internal bus this cycle
import proc_pkg::*;

module proc_param #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] DIN,
  input  logic             Run,
  output logic             Done,
  output logic [WIDTH-1:0] Bus
);

  localparam int RBITS = regFieldWidth(NREGS);

  state_t r_state;
  state_t w_nextState;

  logic [WIDTH-1:0] w_ir;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_regs [NREGS];
  logic [WIDTH-1:0] w_aluOut;

  logic [NREGS-1:0] w_regEn;
  logic             w_irEn;
  logic             w_aEn;
  logic             w_gEn;

  logic [2:0]       w_opcode;
  logic [RBITS-1:0] w_x;
  logic [RBITS-1:0] w_y;
  logic             w_isAlu;
  logic             w_gNonZero;
  logic             w_unusedIr;

  // IR field decode; bits below Y carry no meaning
  assign w_opcode   = w_ir[WIDTH-1 -: 3];
  assign w_x        = w_ir[WIDTH-4 -: RBITS];
  assign w_y        = w_ir[WIDTH-4-RBITS -: RBITS];
  assign w_isAlu    = (w_opcode == OP_ADD) || (w_opcode == OP_SUB) || (w_opcode == OP_AND);
  assign w_gNonZero = |w_g;
  assign w_unusedIr = ^w_ir;

  regn_param #(.WIDTH(WIDTH)) u_ir (
    .i_clk  (Clock),
    .i_rst_n(Resetn),
    .i_en   (w_irEn),
    .i_d    (DIN),
    .o_q    (w_ir)
  );

  regn_param #(.WIDTH(WIDTH)) u_a (
    .i_clk  (Clock),
    .i_rst_n(Resetn),
    .i_en   (w_aEn),
    .i_d    (Bus),
    .o_q    (w_a)
  );

  regn_param #(.WIDTH(WIDTH)) u_g (
    .i_clk  (Clock),
    .i_rst_n(Resetn),
    .i_en   (w_gEn),
    .i_d    (w_aluOut),
    .o_q    (w_g)
  );

  for (genvar i = 0; i < NREGS; i++) begin : g_regs
    regn_param #(.WIDTH(WIDTH)) u_reg (
      .i_clk  (Clock),
      .i_rst_n(Resetn),
      .i_en   (w_regEn[i]),
      .i_d    (Bus),
      .o_q    (w_regs[i])
    );
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= T0;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Only ALU ops continue past T1; everything else retires there
  always_comb begin
    w_nextState = T0;
    case (r_state)
      T0:      w_nextState = Run ? T1 : T0;
      T1:      w_nextState = w_isAlu ? T2 : T0;
      T2:      w_nextState = T3;
      T3:      w_nextState = T0;
      default: w_nextState = T0;
    endcase
  end

  // Subtraction is the two's-complement add A + ~Bus + 1, wrapping freely
  always_comb begin
    w_aluOut = '0;
    case (w_opcode)
      OP_ADD:  w_aluOut = w_a + Bus;
      OP_SUB:  w_aluOut = w_a + ~Bus + WIDTH'(1);
      OP_AND:  w_aluOut = w_a & Bus;
      default: w_aluOut = '0;
    endcase
  end

  // Bus source, Done and register load enables per control step.
  // T2/T3 are only reachable from an ALU op, so they need no opcode check.
  always_comb begin
    Bus     = '0;
    Done    = 1'b0;
    w_irEn  = 1'b0;
    w_aEn   = 1'b0;
    w_gEn   = 1'b0;
    w_regEn = '0;
    case (r_state)
      T0: begin
        w_irEn = Run;
      end
      T1: begin
        case (w_opcode)
          OP_MV: begin
            Bus          = w_regs[w_y];
            w_regEn[w_x] = 1'b1;
            Done         = 1'b1;
          end
          OP_MVI: begin
            Bus          = DIN;
            w_regEn[w_x] = 1'b1;
            Done         = 1'b1;
          end
          OP_MVNZ: begin
            Bus          = w_regs[w_y];
            w_regEn[w_x] = w_gNonZero;
            Done         = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            Bus   = w_regs[w_x];
            w_aEn = 1'b1;
          end
          default: begin
            Done = 1'b1;
          end
        endcase
      end
      T2: begin
        Bus   = w_regs[w_y];
        w_gEn = 1'b1;
      end
      T3: begin
        Bus          = w_g;
        w_regEn[w_x] = 1'b1;
        Done         = 1'b1;
      end
      default: begin
        Bus = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_proc_param.sv
// tb_proc_param
// Bench for proc_param with WIDTH=16, NREGS=8. An instruction-level model
// turns each fetched instruction into the list of (Bus, Done) values its
// execute cycles must show, plus the register/G effects at the end of each
// cycle. One compare process checks the DUT against that list every falling
// edge, and also checks hand-computed literal values posted by the stimulus.
module tb_proc_param;

  logic        Clock;
  logic        Resetn;
  logic        Run;
  logic        Done;
  logic [15:0] DIN;
  logic [15:0] Bus;

  proc_param #(.WIDTH(16), .NREGS(8)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .DIN   (DIN),
    .Run   (Run),
    .Done  (Done),
    .Bus   (Bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    logic        useDin;
    logic [15:0] bus;
    logic        done;
    logic        wr;
    int          idx;
    logic [15:0] val;
    logic        setG;
    logic [15:0] gval;
  } cyc_t;

  cyc_t        expQ[$];
  cyc_t        curCyc;
  logic [15:0] mReg [8];
  logic [15:0] mG;
  logic [2:0]  fOp;
  int          fx;
  int          fy;
  logic [15:0] fRes;

  int          checks = 0;
  int          errors = 0;
  int          litSeq = 0;
  int          litSeen = 0;
  string       litName;
  logic [15:0] litBus;
  logic        litDone;
  logic [15:0] expBus;
  logic        expDone;

  function automatic cyc_t mkCyc(input logic useDin, input logic [15:0] bus,
                                 input logic done, input logic wr, input int idx,
                                 input logic [15:0] val, input logic setG,
                                 input logic [15:0] gval);
    cyc_t c;
    c.useDin = useDin;
    c.bus    = bus;
    c.done   = done;
    c.wr     = wr;
    c.idx    = idx;
    c.val    = val;
    c.setG   = setG;
    c.gval   = gval;
    return c;
  endfunction

  // Instruction-level model: each rising edge either retires the head cycle
  // of the current instruction or, when idle, fetches a new one.
  initial forever begin
    @(posedge Clock or negedge Resetn);
    if (!Resetn) begin
      expQ.delete();
      for (int i = 0; i < 8; i++) mReg[i] = 16'h0000;
      mG = 16'h0000;
    end else if (expQ.size() > 0) begin
      curCyc = expQ.pop_front();
      if (curCyc.setG) mG = curCyc.gval;
      if (curCyc.wr) mReg[curCyc.idx] = curCyc.useDin ? DIN : curCyc.val;
    end else if (Run) begin
      fOp = DIN[15:13];
      fx  = int'(DIN[12:10]);
      fy  = int'(DIN[9:7]);
      case (fOp)
        3'b000: expQ.push_back(mkCyc(1'b0, mReg[fy], 1'b1, 1'b1, fx, mReg[fy], 1'b0, 16'h0));
        3'b001: expQ.push_back(mkCyc(1'b1, 16'h0, 1'b1, 1'b1, fx, 16'h0, 1'b0, 16'h0));
        3'b010, 3'b011, 3'b100: begin
          if (fOp == 3'b010)      fRes = mReg[fx] + mReg[fy];
          else if (fOp == 3'b011) fRes = mReg[fx] - mReg[fy];
          else                    fRes = mReg[fx] & mReg[fy];
          expQ.push_back(mkCyc(1'b0, mReg[fx], 1'b0, 1'b0, 0, 16'h0, 1'b0, 16'h0));
          expQ.push_back(mkCyc(1'b0, mReg[fy], 1'b0, 1'b0, 0, 16'h0, 1'b1, fRes));
          expQ.push_back(mkCyc(1'b0, fRes, 1'b1, 1'b1, fx, fRes, 1'b0, 16'h0));
        end
        3'b101: expQ.push_back(mkCyc(1'b0, mReg[fy], 1'b1, mG != 16'h0, fx, mReg[fy], 1'b0, 16'h0));
        default: expQ.push_back(mkCyc(1'b0, 16'h0, 1'b1, 1'b0, 0, 16'h0, 1'b0, 16'h0));
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Single compare process: model check every cycle, plus any posted literal
  initial forever begin
    @(negedge Clock);
    if (!Resetn || expQ.size() == 0) begin
      expBus  = 16'h0000;
      expDone = 1'b0;
    end else begin
      expBus  = expQ[0].useDin ? DIN : expQ[0].bus;
      expDone = expQ[0].done;
    end
    checkOutput("modelBus", Bus, expBus);
    checkOutput("modelDone", {15'd0, Done}, {15'd0, expDone});
    if (litSeq != litSeen) begin
      litSeen = litSeq;
      checkOutput({litName, "Bus"}, Bus, litBus);
      checkOutput({litName, "Done"}, {15'd0, Done}, {15'd0, litDone});
    end
  end

  // Posts a literal expectation for the coming falling edge
  task automatic applyExpect(input string name, input logic [15:0] bus, input logic done);
    litName = name;
    litBus  = bus;
    litDone = done;
    litSeq++;
  endtask

  // Fetch one instruction and step to its Done cycle, checking that cycle
  task automatic applyStimulus(input string name, input logic [15:0] instr,
                               input logic [15:0] imm, input logic [15:0] lastBus,
                               input logic toggleRun);
    int n;
    @(posedge Clock);
    #1;
    DIN = instr;
    Run = 1'b1;
    @(posedge Clock);
    #1;
    Run = toggleRun;
    DIN = imm;
    n = (instr[15:13] == 3'b010 || instr[15:13] == 3'b011 || instr[15:13] == 3'b100) ? 3 : 1;
    for (int k = 1; k < n; k++) begin
      @(posedge Clock);
      #1;
      if (toggleRun) Run = ~Run;
    end
    #2;
    applyExpect(name, lastBus, 1'b1);
    Run = 1'b0;
  endtask

  initial begin
    Resetn = 1'b0;
    Run    = 1'b0;
    DIN    = 16'h0000;
    #2;
    applyExpect("reset", 16'h0000, 1'b0);
    #10;
    Resetn = 1'b1;

    applyStimulus("mviR0", 16'h2000, 16'h0005, 16'h0005, 1'b0);
    applyStimulus("mviR1", 16'h2400, 16'h0003, 16'h0003, 1'b0);
    applyStimulus("addR0R1", 16'h4080, 16'h0000, 16'h0008, 1'b0);
    applyStimulus("subWrap", 16'h6400, 16'h0000, 16'hFFFB, 1'b0);
    applyStimulus("mvnzTaken", 16'hA800, 16'h0000, 16'h0008, 1'b0);
    applyStimulus("readR2a", 16'h0900, 16'h0000, 16'h0008, 1'b0);
    applyStimulus("andZero", 16'h8D80, 16'h0000, 16'h0000, 1'b0);
    applyStimulus("mvnzSkip", 16'hA880, 16'h0000, 16'hFFFB, 1'b0);
    applyStimulus("readR2b", 16'h0900, 16'h0000, 16'h0008, 1'b0);
    applyStimulus("reserved", 16'hC000, 16'h0000, 16'h0000, 1'b0);
    applyStimulus("readR2c", 16'h0900, 16'h0000, 16'h0008, 1'b0);
    applyStimulus("addRunToggle", 16'h4080, 16'h0000, 16'h0003, 1'b1);
    applyStimulus("readR0", 16'h0000, 16'h0000, 16'h0003, 1'b0);

    // Run held high: fetch and T1 alternate back to back
    @(posedge Clock);
    #1;
    DIN = 16'h0900;
    Run = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge Clock);
      #2;
      if (k % 2 == 1) applyExpect("chainT1", 16'h0008, 1'b1);
      else            applyExpect("chainT0", 16'h0000, 1'b0);
    end
    Run = 1'b0;

    // Reset asserted in T2 of an add
    @(posedge Clock);
    #1;
    DIN = 16'h4080;
    Run = 1'b1;
    @(posedge Clock);
    #1;
    Run = 1'b0;
    DIN = 16'h0000;
    @(posedge Clock);
    #1;
    Resetn = 1'b0;
    #1;
    applyExpect("resetMidAdd", 16'h0000, 1'b0);
    @(posedge Clock);
    #3;
    Resetn = 1'b1;
    @(posedge Clock);
    #2;
    applyExpect("idleAfterReset", 16'h0000, 1'b0);
    repeat (2) @(posedge Clock);
    #2;
    applyExpect("idleAfterReset2", 16'h0000, 1'b0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("zeroR%0d", i), 16'(i << 7), 16'h0000, 16'h0000, 1'b0);
    end

    // X == Y: add doubles, sub clears
    applyStimulus("mviR1seven", 16'h2400, 16'h0007, 16'h0007, 1'b0);
    applyStimulus("addDouble", 16'h4480, 16'h0000, 16'h000E, 1'b0);
    applyStimulus("subSelf", 16'h6480, 16'h0000, 16'h0000, 1'b0);
    applyStimulus("readR1", 16'h0080, 16'h0000, 16'h0000, 1'b0);

    repeat (2) @(posedge Clock);
    #6;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
